// File: rtl/conv_pkg.sv
// Shared widths and types for the convolution multiply-accumulate stage.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 26;
  localparam int IDX_W  = 18;
  localparam int WIN_W  = 10;

  typedef logic signed [DATA_W-1:0]   pix_t;
  typedef logic signed [2*DATA_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]    acc_t;
  typedef logic [WIN_W-1:0]           win_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  // A window length of 0 behaves as a single-sample window.
  function automatic win_t last_index(input win_t len);
    return (len == '0) ? '0 : len - win_t'(1);
  endfunction

endpackage

// File: rtl/conv_res_fifo.sv
// Synchronous result FIFO; push into a full FIFO is only legal alongside a pop.
module conv_res_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [ACC_W-1:0]       push_data,
  input  logic                   pop,
  output logic [ACC_W-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  acc_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/conv_window_mac.sv
// Window multiply-accumulate with result FIFO and upstream stall.
// Define CONV_RELU_EN to clamp negative results to 0 on entry to the FIFO.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [WIN_W-1:0]         win_len,
  input  logic signed [DATA_W-1:0] pix_data,
  input  logic signed [DATA_W-1:0] kern_data,
  input  logic                     conv_done,
  output logic                     stall,
  output logic signed [ACC_W-1:0]  res_data,
  output logic [IDX_W-1:0]         res_idx,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     frame_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [RD_LAT-1:0] vld_dly;
  logic              in_valid;
  win_t              samp_cnt;
  logic              in_first;
  logic              in_last;

  tag_t  s1_tag;
  pix_t  s1_pix;
  pix_t  s1_kern;
  tag_t  s2_tag;
  prod_t prod;
  acc_t  acc;
  acc_t  sum;
  acc_t  push_data;
  logic  push;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop_fire;
  logic          done_pend;
  logic          pipe_empty;
  logic          frame_end;

  assign in_valid = vld_dly[RD_LAT-1];
  assign in_first = (samp_cnt == '0);
  assign in_last  = (samp_cnt == last_index(win_len));

  assign sum  = (s2_tag.first ? '0 : acc) + acc_t'(prod);
  assign push = s2_tag.valid && s2_tag.last;

`ifdef CONV_RELU_EN
  assign push_data = sum[ACC_W-1] ? '0 : sum;
`else
  assign push_data = sum;
`endif

  // Every sample already in flight must still find a free slot once stall rises.
  assign stall = fifo_full || ((CW'(FIFO_DEPTH) - fifo_count) <= CW'(RD_LAT + 2));

  assign res_valid  = !fifo_empty;
  assign pop_fire   = res_valid && res_ready;
  assign pipe_empty = (vld_dly == '0) && !s1_tag.valid && !s2_tag.valid;
  assign frame_end  = done_pend && pipe_empty && fifo_empty;

  // Valid delay line matching memory read latency, then operand capture and multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_dly  <= '0;
      samp_cnt <= '0;
      s1_tag   <= '0;
      s1_pix   <= '0;
      s1_kern  <= '0;
      s2_tag   <= '0;
      prod     <= '0;
    end else begin
      vld_dly[0] <= enable;
      for (int i = 1; i < RD_LAT; i++) vld_dly[i] <= vld_dly[i-1];

      if (frame_end)
        samp_cnt <= '0;
      else if (in_valid)
        samp_cnt <= in_last ? '0 : samp_cnt + win_t'(1);

      s1_tag  <= '{valid: in_valid, first: in_first, last: in_last};
      s1_pix  <= pix_data;
      s1_kern <= kern_data;

      s2_tag  <= s1_tag;
      prod    <= s1_pix * s1_kern;
    end
  end

  // The accumulator restarts on each window's first product and is never clamped.
  always_ff @(posedge clk) begin
    if (reset)
      acc <= '0;
    else if (s2_tag.valid)
      acc <= sum;
  end

  // Frame completion waits until every sample of the frame has been popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_pend  <= 1'b0;
      frame_done <= 1'b0;
      res_idx    <= '0;
    end else begin
      frame_done <= frame_end;
      done_pend  <= frame_end ? 1'b0 : (done_pend || conv_done);
      if (frame_end)
        res_idx <= '0;
      else if (pop_fire)
        res_idx <= res_idx + IDX_W'(1);
    end
  end

  conv_res_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (res_ready),
    .head     (res_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac; CONV_RELU_EN selects the ReLU expectation.
module tb_conv_window_mac;
  import conv_pkg::*;

  localparam int RD_LAT     = 1;
  localparam int FIFO_DEPTH = 8;

  logic                     clk       = 1'b0;
  logic                     reset     = 1'b1;
  logic                     enable    = 1'b0;
  logic                     conv_done = 1'b0;
  logic                     res_ready = 1'b1;
  logic [WIN_W-1:0]         win_len   = 10'd1;
  logic signed [DATA_W-1:0] pix_data  = '0;
  logic signed [DATA_W-1:0] kern_data = '0;
  logic                     stall;
  logic signed [ACC_W-1:0]  res_data;
  logic [IDX_W-1:0]         res_idx;
  logic                     res_valid;
  logic                     frame_done;

  conv_window_mac #(
    .RD_LAT    (RD_LAT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .win_len   (win_len),
    .pix_data  (pix_data),
    .kern_data (kern_data),
    .conv_done (conv_done),
    .stall     (stall),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    acc_t             data;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             head_e;
  int               n_cmp = 0;
  int               n_fail = 0;
  int               pop_cnt = 0;
  int               fd_cnt = 0;
  int               tb_cnt = 0;
  int               tb_acc = 0;
  logic [IDX_W-1:0] exp_idx = '0;
  logic             toggle_ready = 1'b0;
  pix_t             pend_pix = '0;
  pix_t             pend_kern = '0;

  // Pixel RAM / kernel ROM with a one-cycle read latency.
  always @(posedge clk) begin
    if (enable) begin
      pix_data  <= pend_pix;
      kern_data <= pend_kern;
    end
  end

  // Scoreboard: every accepted result must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) fd_cnt++;
      if (res_valid && res_ready) begin
        pop_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL pop_unexpected: got data=%0d idx=%0d, required no result", res_data, res_idx);
        end else begin
          head_e = exp_q.pop_front();
          if (res_data !== head_e.data || res_idx !== head_e.idx) begin
            n_fail++;
            $display("[TB] FAIL result: got data=%0d idx=%0d, required data=%0d idx=%0d",
                     res_data, res_idx, head_e.data, head_e.idx);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_ready) res_ready = ~res_ready;
  endtask

  task automatic flush_model();
    exp_q.delete();
    tb_cnt  = 0;
    tb_acc  = 0;
    exp_idx = '0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    conv_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    flush_model();
  endtask

  task automatic issue(input int p, input int k);
    int   w = 0;
    int   len;
    int   r;
    exp_t e;
    if (stall) enable = 1'b0;
    while (stall && w < 100) begin
      tick();
      w++;
    end
    if (stall) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL stall_timeout: stall still %b after %0d cycles, required 0", stall, w);
    end
    len    = (win_len == '0) ? 1 : int'(win_len);
    tb_acc = ((tb_cnt == 0) ? 0 : tb_acc) + p * k;
    if (tb_cnt == len - 1) begin
      r = tb_acc;
`ifdef CONV_RELU_EN
      if (r < 0) r = 0;
`endif
      e.data  = acc_t'(r);
      e.idx   = exp_idx;
      exp_idx = exp_idx + IDX_W'(1);
      exp_q.push_back(e);
      tb_cnt = 0;
    end else begin
      tb_cnt++;
    end
    enable    = 1'b1;
    pend_pix  = pix_t'(p);
    pend_kern = pix_t'(k);
    tick();
  endtask

  task automatic wait_drain(input int bound);
    int w = 0;
    while ((exp_q.size() != 0 || res_valid) && w < bound) begin
      tick();
      w++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || res_valid) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d results outstanding, res_valid=%b, required 0 and 0", exp_q.size(), res_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 5;
    if (res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_res_valid: got %b, required 0", res_valid); end
    if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b, required 0", stall); end
    if (res_data !== '0) begin n_fail++; $display("[TB] FAIL reset_res_data: got %0d, required 0", res_data); end
    if (res_idx !== '0) begin n_fail++; $display("[TB] FAIL reset_res_idx: got %0d, required 0", res_idx); end
    if (frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_done: got %b, required 0", frame_done); end
  endtask

  task automatic test_latency();
    int lat = 1;
    win_len   = 10'd4;
    res_ready = 1'b1;
    for (int i = 1; i <= 4; i++) issue(i, 1);
    enable = 1'b0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat != RD_LAT + 3) begin
      n_fail++;
      $display("[TB] FAIL latency: got %0d cycles, required %0d", lat, RD_LAT + 3);
    end
    wait_drain(30);
  endtask

  task automatic test_signed();
    int   w = 0;
    acc_t want;
`ifdef CONV_RELU_EN
    want = '0;
`else
    want = -26'sd146304;
`endif
    win_len = 10'd9;
    for (int i = 0; i < 9; i++) issue(-128, 127);
    enable = 1'b0;
    while (!res_valid && w < 20) begin
      tick();
      w++;
    end
    n_cmp++;
    if (res_data !== want) begin
      n_fail++;
      $display("[TB] FAIL signed_window: got %0d, required %0d", res_data, want);
    end
    wait_drain(30);
  endtask

  task automatic test_stall();
    int n_iss = 0;
    int p0;
    win_len   = 10'd1;
    res_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (stall) break;
      issue(i * 5 - 17, 3);
      n_iss++;
    end
    enable = 1'b0;
    n_cmp++;
    if (n_iss != FIFO_DEPTH) begin
      n_fail++;
      $display("[TB] FAIL stall_rise: got %0d enables before stall, required %0d", n_iss, FIFO_DEPTH);
    end
    repeat (6) tick();
    n_cmp += 4;
    if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_hold: got %b, required 1", stall); end
    if (res_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL full_valid: got %b, required 1", res_valid); end
    if (res_data !== exp_q[0].data) begin n_fail++; $display("[TB] FAIL hold_data: got %0d, required %0d", res_data, exp_q[0].data); end
    if (res_idx !== exp_q[0].idx) begin n_fail++; $display("[TB] FAIL hold_idx: got %0d, required %0d", res_idx, exp_q[0].idx); end
    p0 = pop_cnt;
    res_ready = 1'b1;
    wait_drain(40);
    n_cmp += 2;
    if (pop_cnt - p0 != FIFO_DEPTH) begin n_fail++; $display("[TB] FAIL drain_count: got %0d, required %0d", pop_cnt - p0, FIFO_DEPTH); end
    if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_release: got %b, required 0", stall); end
  endtask

  task automatic test_frame();
    int p0;
    int f0;
    int w = 0;
    do_reset();
    win_len      = 10'd9;
    p0           = pop_cnt;
    f0           = fd_cnt;
    toggle_ready = 1'b1;
    for (int wi = 0; wi < 6; wi++) begin
      for (int s = 0; s < 9; s++) begin
        if (wi == 5 && s == 8) conv_done = 1'b1;
        issue(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
        conv_done = 1'b0;
      end
    end
    enable = 1'b0;
    while (!frame_done && w < 300) begin
      tick();
      w++;
    end
    n_cmp += 3;
    if (frame_done !== 1'b1) begin n_fail++; $display("[TB] FAIL frame_done_seen: got %b after %0d cycles, required 1", frame_done, w); end
    if (pop_cnt - p0 != 6) begin n_fail++; $display("[TB] FAIL frame_pops: got %0d, required 6", pop_cnt - p0); end
    if (res_idx !== '0) begin n_fail++; $display("[TB] FAIL frame_idx_clear: got %0d, required 0", res_idx); end
    exp_idx      = '0;
    toggle_ready = 1'b0;
    res_ready    = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (fd_cnt - f0 != 1) begin n_fail++; $display("[TB] FAIL frame_done_pulses: got %0d, required 1", fd_cnt - f0); end
  endtask

  task automatic test_back_to_back();
    int p0;
    win_len   = 10'd2;
    res_ready = 1'b1;
    p0        = pop_cnt;
    issue(7, 1);
    issue(-3, 1);
    issue(100, 1);
    issue(20, 1);
    enable = 1'b0;
    wait_drain(30);
    n_cmp++;
    if (pop_cnt - p0 != 2) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d, required 2", pop_cnt - p0); end
  endtask

  task automatic test_reset_mid();
    int f0;
    do_reset();
    win_len   = 10'd3;
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) issue(i + 1, 2);
    enable = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (res_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_queued: got %b, required 1", res_valid); end
    issue(50, 50);
    enable = 1'b0;
    reset  = 1'b1;
    f0     = fd_cnt;
    tick();
    n_cmp += 3;
    if (res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_valid: got %b, required 0", res_valid); end
    if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_stall: got %b, required 0", stall); end
    if (res_idx !== '0) begin n_fail++; $display("[TB] FAIL mid_reset_idx: got %0d, required 0", res_idx); end
    reset = 1'b0;
    flush_model();
    res_ready = 1'b1;
    issue(10, 2);
    issue(20, 2);
    issue(30, 2);
    enable = 1'b0;
    wait_drain(30);
    n_cmp++;
    if (fd_cnt != f0) begin n_fail++; $display("[TB] FAIL mid_frame_done: got %0d pulses, required 0", fd_cnt - f0); end
  endtask

  initial begin
    $display("[TB] conv_window_mac bench start");
    test_reset();
    test_latency();
    test_signed();
    test_stall();
    test_frame();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
